// File: rtl/usb_rx_ctrl_pkg.sv
// usb_rx_pkg: shared types and constants for the USB receive controller
package usb_rx_pkg;
    localparam int         BYTE_CNT_W    = 7;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

    typedef enum logic [3:0] {
        IDLE,
        SYNC_RCV,
        CHK_SYNC,
        DATA_RCV,
        STORE,
        EOP_WAIT,
        ERR_DRAIN,
        ERR_EOP_WAIT,
        ERR_IDLE
    } rx_state_t;
endpackage

// File: rtl/usb_rx_ctrl_if.sv
// usb_rx_ctrl_if: detector/shift-register/FIFO signals around the receive controller
interface usb_rx_ctrl_if import usb_rx_pkg::*; ();
    logic                  d_edge;
    logic                  eop;
    logic                  shift_en;
    logic                  byte_received;
    logic [7:0]            rcv_data;
    logic                  fifo_full;
    logic                  rcving;
    logic                  w_enable;
    logic                  r_error;
    logic                  pkt_done;
    logic [BYTE_CNT_W-1:0] byte_cnt;

    modport master (
        output d_edge, eop, shift_en, byte_received, rcv_data, fifo_full,
        input  rcving, w_enable, r_error, pkt_done, byte_cnt
    );

    modport slave (
        input  d_edge, eop, shift_en, byte_received, rcv_data, fifo_full,
        output rcving, w_enable, r_error, pkt_done, byte_cnt
    );
endinterface

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: packet sequencer for the USB 1.1 receiver (SYNC check, byte stores, EOP alignment, sticky errors)
module usb_rx_ctrl import usb_rx_pkg::*; #(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_BYTES = 64
) (
    input logic          clk,
    input logic          n_rst,
    usb_rx_ctrl_if.slave bus
);
    localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_BYTES);

    rx_state_t             state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  w_enable_q, w_enable_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  eop_samp;

    assign eop_samp = bus.eop && bus.shift_en;

    // State, counters and registered strobes; reset drops straight back to IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            w_enable_q <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            w_enable_q <= w_enable_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // Next-state and counter updates; write and done strobes are registered so they land one cycle after the deciding state
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        w_enable_d = 1'b0;
        pkt_done_d = 1'b0;
        case (state_q)
            IDLE: if (bus.d_edge) begin
                state_d    = SYNC_RCV;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
            end
            SYNC_RCV: begin
                if (eop_samp) state_d = ERR_EOP_WAIT;
                else if (bus.byte_received) begin
                    state_d   = CHK_SYNC;
                    bit_cnt_d = '0;
                end
            end
            CHK_SYNC: state_d = (bus.rcv_data == SYNC_BYTE) ? DATA_RCV : ERR_DRAIN;
            DATA_RCV: begin
                if (eop_samp) begin
                    state_d    = (bit_cnt_q == 3'd0) ? EOP_WAIT : ERR_EOP_WAIT;
                    pkt_done_d = (bit_cnt_q == 3'd0);
                end else if (bus.byte_received) begin
                    state_d   = STORE;
                    bit_cnt_d = '0;
                end else if (bus.shift_en) bit_cnt_d = bit_cnt_q + 3'd1;
            end
            STORE: begin
                if (!bus.fifo_full && byte_cnt_q < MAX_CNT) begin
                    state_d    = DATA_RCV;
                    w_enable_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end else state_d = ERR_DRAIN;
            end
            EOP_WAIT:     if (bus.d_edge) state_d = IDLE;
            ERR_DRAIN:    if (eop_samp) state_d = ERR_EOP_WAIT;
            ERR_EOP_WAIT: if (bus.d_edge) state_d = ERR_IDLE;
            ERR_IDLE: if (bus.d_edge) begin
                state_d    = SYNC_RCV;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rcving   = state_q inside {SYNC_RCV, CHK_SYNC, DATA_RCV, STORE, ERR_DRAIN};
    assign bus.r_error  = state_q inside {ERR_DRAIN, ERR_EOP_WAIT, ERR_IDLE};
    assign bus.w_enable = w_enable_q;
    assign bus.pkt_done = pkt_done_q;
    assign bus.byte_cnt = byte_cnt_q;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed checks of the USB receive controller
module tb_usb_rx_ctrl;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    logic we_a, we_b;

    usb_rx_ctrl_if bus ();

    usb_rx_ctrl #(.MAX_BYTES(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count write and done pulses mid-cycle
    always @(negedge clk) begin
        if (bus.w_enable) wr_cnt++;
        if (bus.pkt_done) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic de, input logic eo, input logic se, input logic br);
        bus.d_edge = de;
        bus.eop = eo;
        bus.shift_en = se;
        bus.byte_received = br;
        @(posedge clk);
        #1;
        bus.d_edge = 1'b0;
        bus.shift_en = 1'b0;
        bus.byte_received = 1'b0;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(8);
        bus.rcv_data = b;
        cyc(0, 0, 0, 1);
        we_a = bus.w_enable;
        cyc(0, 0, 0, 0);
        we_b = bus.w_enable;
        cyc(0, 0, 0, 0);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_rcving"}, int'(bus.rcving), 0);
        chk({tag, "_wen"}, int'(bus.w_enable), 0);
        chk({tag, "_rerr"}, int'(bus.r_error), 0);
        chk({tag, "_done"}, int'(bus.pkt_done), 0);
        chk({tag, "_bcnt"}, int'(bus.byte_cnt), 0);
    endtask

    initial begin
        bus.d_edge = 0;
        bus.eop = 0;
        bus.shift_en = 0;
        bus.byte_received = 0;
        bus.rcv_data = 8'h00;
        bus.fifo_full = 0;
        repeat (3) @(posedge clk);
        #1;
        outs_zero("rst");
        n_rst = 1'b1;
        cyc(0, 0, 0, 0);
        outs_zero("post_rst");

        // good packet
        cyc(1, 0, 0, 0);
        chk("t1_rcving", int'(bus.rcving), 1);
        send_byte(8'h80);
        chk("t1_sync_nowr", wr_cnt, 0);
        send_byte(8'hA5);
        chk("t1_lat1", int'(we_a), 0);
        chk("t1_lat2", int'(we_b), 1);
        chk("t1_bcnt1", int'(bus.byte_cnt), 1);
        send_byte(8'h3C);
        chk("t1_writes", wr_cnt, 2);
        cyc(0, 1, 1, 0);
        chk("t1_done", int'(bus.pkt_done), 1);
        chk("t1_rcving_off", int'(bus.rcving), 0);
        chk("t1_rerr", int'(bus.r_error), 0);
        cyc(0, 1, 0, 0);
        chk("t1_done_pulse", int'(bus.pkt_done), 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t1_idle_rcving", int'(bus.rcving), 0);
        chk("t1_bcnt2", int'(bus.byte_cnt), 2);
        chk("t1_done_cnt", done_cnt, 1);

        // bad SYNC
        cyc(1, 0, 0, 0);
        chk("t2_bcnt_clr", int'(bus.byte_cnt), 0);
        send_byte(8'h81);
        chk("t2_rerr_drain", int'(bus.r_error), 1);
        chk("t2_rcving", int'(bus.rcving), 1);
        send_byte(8'hA5);
        chk("t2_nowr", wr_cnt, 2);
        cyc(0, 1, 1, 0);
        chk("t2_rerr_eop", int'(bus.r_error), 1);
        chk("t2_rcving_off", int'(bus.rcving), 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t2_rerr_idle", int'(bus.r_error), 1);
        cyc(1, 0, 0, 0);
        chk("t2_rerr_clr", int'(bus.r_error), 0);
        chk("t2_restart", int'(bus.rcving), 1);

        // mid-byte EOP
        send_byte(8'h80);
        send_bits(3);
        cyc(0, 1, 1, 0);
        chk("t3_rerr", int'(bus.r_error), 1);
        chk("t3_rcving", int'(bus.rcving), 0);
        chk("t3_done", int'(bus.pkt_done), 0);
        chk("t3_nowr", wr_cnt, 2);
        cyc(1, 0, 0, 0);

        // FIFO full
        cyc(1, 0, 0, 0);
        chk("t4_bcnt_clr", int'(bus.byte_cnt), 0);
        send_byte(8'h80);
        send_byte(8'h11);
        bus.fifo_full = 1'b1;
        send_byte(8'h22);
        bus.fifo_full = 1'b0;
        chk("t4_nowr", int'(we_b), 0);
        chk("t4_rerr", int'(bus.r_error), 1);
        chk("t4_bcnt", int'(bus.byte_cnt), 1);
        chk("t4_writes", wr_cnt, 3);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 0, 0);

        // overflow at MAX_BYTES=4
        cyc(1, 0, 0, 0);
        send_byte(8'h80);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1));
        chk("t5_rerr_ok", int'(bus.r_error), 0);
        chk("t5_bcnt4", int'(bus.byte_cnt), 4);
        send_byte(8'h55);
        chk("t5_nowr", int'(we_b), 0);
        chk("t5_rerr", int'(bus.r_error), 1);
        chk("t5_bcnt_sat", int'(bus.byte_cnt), 4);
        chk("t5_writes", wr_cnt, 7);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 0, 0);

        // async reset mid-byte
        cyc(1, 0, 0, 0);
        send_byte(8'h80);
        send_byte(8'h66);
        chk("t6_writes_pre", wr_cnt, 8);
        send_bits(8);
        n_rst = 1'b0;
        #1;
        outs_zero("t6_async");
        bus.rcv_data = 8'h77;
        cyc(0, 0, 0, 1);
        n_rst = 1'b1;
        repeat (3) cyc(0, 0, 0, 0);
        chk("t6_nowr", wr_cnt, 8);
        chk("t6_idle", int'(bus.rcving), 0);
        cyc(1, 0, 0, 0);
        chk("t6_rcving", int'(bus.rcving), 1);
        chk("t6_bcnt_clr", int'(bus.byte_cnt), 0);
        send_byte(8'h80);
        send_byte(8'h99);
        chk("t6_bcnt1", int'(bus.byte_cnt), 1);
        chk("t6_writes", wr_cnt, 9);
        chk("final_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
